stepper_driver: RTL

Converts a motion command written by the processor (step count in `reg_24`, step period in `reg_25`) into a timed coil-phase sequence on the `JA` Pmod pins that drive the stepper motor. It sits directly downstream of the processor/regfile pair. It owns the step-rate timer, the remaining-step counter and the phase sequencer, and reports `busy` and `done` back to software through the `SW`-style status path.

---
 rtl/stepper_driver_pkg.sv | 20 ++
 rtl/stepper_driver_if.sv | 26 ++
 rtl/stepper_driver_step_rate_timer.sv | 30 +++
 rtl/stepper_driver.sv | 130 +++++++++++++
 4 files changed

// File: rtl/stepper_driver_pkg.sv
// Shared stepper definitions: coil phase table, controller states, JA pin map.
// Combinational constants only; no latency or flow-control behaviour here.
package stepper_pkg;

  typedef enum logic {IDLE, RUN} state_t;

  localparam int CMD_WIDTH   = 32;
  localparam int JA_WIDTH    = 6;
  localparam int JA_COIL_LSB = 0;
  localparam int JA_COIL_MSB = 3;
  localparam int JA_ENABLE   = 4;
  localparam int JA_STEP     = 5;

  // Coil bits are A+,B+,A-,B- from MSB to LSB; odd entries energise two coils.
  localparam logic [3:0] PHASE_TABLE [0:7] = '{
    4'b1000, 4'b1100, 4'b0100, 4'b0110,
    4'b0010, 4'b0011, 4'b0001, 4'b1001
  };

endpackage

// File: rtl/stepper_driver_if.sv
// Command/status bundle between the processor regfile and the stepper driver.
// The master issues commands when cmd_ready is high; the slave drives coils and status.
interface stepper_driver_if;
  import stepper_pkg::*;

  logic [CMD_WIDTH-1:0] cmd_steps;
  logic [CMD_WIDTH-1:0] cmd_period;
  logic                 half_step;
  logic                 cmd_valid;
  logic                 cmd_ready;
  logic                 stop;
  logic [JA_WIDTH-1:0]  JA;
  logic                 busy;
  logic                 done;

  modport master (
    output cmd_steps, cmd_period, half_step, cmd_valid, stop,
    input  cmd_ready, JA, busy, done
  );

  modport slave (
    input  cmd_steps, cmd_period, half_step, cmd_valid, stop,
    output cmd_ready, JA, busy, done
  );

endinterface

// File: rtl/stepper_driver_step_rate_timer.sv
// Loadable down-counter; tc is high while enabled and the count sits at zero.
// Load takes effect on the next edge and wins over counting; no backpressure.
module step_rate_timer
  import stepper_pkg::*;
#(
  parameter int WIDTH = CMD_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             enable,
  output logic             tc
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clock) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (enable && (count != '0)) begin
      count <= count - WIDTH'(1);
    end
  end

  assign tc = enable && (count == '0);

endmodule

// File: rtl/stepper_driver.sv
// Turns a signed step count and step period into timed coil phases on JA; first step one period after accept.
// Accepts a command only while idle (cmd_ready); commands during a move are dropped, stop aborts it.
module stepper_driver
  import stepper_pkg::*;
#(
  parameter int unsigned MIN_PERIOD = 16,
  parameter bit          HOLD       = 1'b1
) (
  input  logic             clock,
  input  logic             reset,
  stepper_driver_if.slave  bus
);

  state_t               state, state_next;
  logic [2:0]           index;
  logic [CMD_WIDTH-1:0] remaining;
  logic [CMD_WIDTH-1:0] period;
  logic                 dir_rev;
  logic                 half_mode;
  logic                 accepted;
  logic                 done_q;
  logic                 step_pulse;

  logic [CMD_WIDTH-1:0] mag;
  logic [CMD_WIDTH-1:0] period_clamped;
  logic                 start, zero_cmd, advance, finish, abort, tc;
  logic [2:0]           stride, index_next;
  logic [3:0]           coils;
  logic [JA_WIDTH-1:0]  ja;

  // Two's-complement negate leaves -2^31 as 0x80000000, which is the right unsigned magnitude.
  always_comb begin
    mag            = bus.cmd_steps[CMD_WIDTH-1] ? (CMD_WIDTH'(0) - bus.cmd_steps) : bus.cmd_steps;
    period_clamped = (bus.cmd_period < MIN_PERIOD) ? MIN_PERIOD : bus.cmd_period;
    stride         = half_mode ? 3'd1 : 3'd2;
    index_next     = dir_rev ? (index - stride) : (index + stride);
  end

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // A final step that coincides with stop still completes; any other stop freezes the index.
  always_comb begin
    state_next = state;
    start      = 1'b0;
    zero_cmd   = 1'b0;
    advance    = 1'b0;
    finish     = 1'b0;
    abort      = 1'b0;
    case (state)
      IDLE: begin
        if (bus.cmd_valid) begin
          if (mag != '0) begin
            start      = 1'b1;
            state_next = RUN;
          end else begin
            zero_cmd = 1'b1;
          end
        end
      end
      RUN: begin
        if (tc && (remaining == CMD_WIDTH'(1))) begin
          advance    = 1'b1;
          finish     = 1'b1;
          state_next = IDLE;
        end else if (bus.stop) begin
          abort      = 1'b1;
          state_next = IDLE;
        end else if (tc) begin
          advance = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      index      <= '0;
      remaining  <= '0;
      period     <= '0;
      dir_rev    <= 1'b0;
      half_mode  <= 1'b0;
      accepted   <= 1'b0;
      done_q     <= 1'b0;
      step_pulse <= 1'b0;
    end else begin
      done_q     <= finish || abort || zero_cmd;
      step_pulse <= advance;
      if (start) begin
        dir_rev   <= bus.cmd_steps[CMD_WIDTH-1];
        remaining <= mag;
        period    <= period_clamped;
        half_mode <= bus.half_step;
        accepted  <= 1'b1;
        if (!bus.half_step) index <= index | 3'd1;
      end
      if (advance) begin
        index     <= index_next;
        remaining <= remaining - CMD_WIDTH'(1);
      end
    end
  end

  step_rate_timer #(.WIDTH(CMD_WIDTH)) u_timer (
    .clock      (clock),
    .reset      (reset),
    .load       (start || advance),
    .load_value (start ? (period_clamped - CMD_WIDTH'(1)) : (period - CMD_WIDTH'(1))),
    .enable     (state == RUN),
    .tc         (tc)
  );

  always_comb begin
    coils = 4'b0000;
    if ((state == RUN) || (HOLD && accepted)) coils = PHASE_TABLE[index];
    ja                         = '0;
    ja[JA_COIL_MSB:JA_COIL_LSB] = coils;
    ja[JA_ENABLE]              = |coils;
    ja[JA_STEP]                = step_pulse;
  end

  assign bus.JA        = ja;
  assign bus.busy      = (state == RUN);
  assign bus.cmd_ready = (state == IDLE);
  assign bus.done      = done_q;

endmodule
